// File: rtl/core_mem_pkg.sv
// Shared definitions for the core-to-memory arbiter: FSM encoding, core count
// and default bus widths.
package core_mem_pkg;

    localparam int N_CORES    = 4;
    localparam int IDX_W      = $clog2(N_CORES);
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

endpackage

// File: rtl/core_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after last_grant,
// wrapping modulo the core count. Reusable by any shared-resource arbiter.
module rr_pick
    import core_mem_pkg::*;
(
    input  logic [N_CORES-1:0] elig,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   win,
    output logic               vld
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        win = '0;
        vld = 1'b0;
        idx = '0;
        // Offset N_CORES wraps to last_grant itself, so it is the lowest priority.
        for (int i = 1; i <= N_CORES; i++) begin
            idx = last_grant + IDX_W'(i);
            if (!vld && elig[idx]) begin
                win = idx;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between up to
// four cores; each access is a fixed IDLE -> ACCESS -> RESP sequence.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CORES-1:0]        n_cores,
    input  logic [N_CORES-1:0]        core_req,
    input  logic [N_CORES-1:0]        core_wr,
    input  logic [N_CORES*ADDR_W-1:0] core_addr,
    input  logic [N_CORES*DATA_W-1:0] core_wdata,
    output logic [N_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]         core_rdata,
    output logic                      mem_en,
    output logic                      mem_wr,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [1:0]                state
);

    state_t             st, st_next;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   win;
    logic               win_vld;
    logic [N_CORES-1:0] elig;

    // A core whose ack is on the wire this cycle must not be re-granted.
    assign elig  = core_req & n_cores & ~core_ack;
    assign state = st;

    rr_pick u_rr_pick (
        .elig       (elig),
        .last_grant (last_grant),
        .win        (win),
        .vld        (win_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
        end else begin
            st <= st_next;
        end
    end

    always_comb begin
        st_next = IDLE;
        case (st)
            IDLE:    st_next = win_vld ? ACCESS : IDLE;
            ACCESS:  st_next = RESP;
            RESP:    st_next = IDLE;
            default: st_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_ack   <= '0;
            core_rdata <= '0;
            grant      <= '0;
            last_grant <= IDX_W'(N_CORES - 1);
        end else begin
            mem_en   <= 1'b0;
            core_ack <= '0;
            case (st)
                IDLE: begin
                    if (win_vld) begin
                        mem_en    <= 1'b1;
                        mem_wr    <= core_wr[win];
                        mem_addr  <= core_addr[int'(win)*ADDR_W +: ADDR_W];
                        mem_wdata <= core_wdata[int'(win)*DATA_W +: DATA_W];
                        grant     <= win;
                    end
                end
                RESP: begin
                    core_rdata      <= mem_rdata;
                    core_ack[grant] <= 1'b1;
                    last_grant      <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter with a behavioural memory and an
// expected-ack scoreboard.
module tb_core_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_ACC  = 2'b01;
    localparam logic [1:0] S_RESP = 2'b10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    n_cores = '0;
    logic [3:0]    core_req = '0;
    logic [3:0]    core_wr = '0;
    logic [4*AW-1:0] core_addr = '0;
    logic [4*DW-1:0] core_wdata = '0;
    logic [3:0]    core_ack;
    logic [DW-1:0] core_rdata;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    state;

    core_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .n_cores    (n_cores),
        .core_req   (core_req),
        .core_wr    (core_wr),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .state      (state)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:4095];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            core;
        logic [DW-1:0] data;
        bit            chk;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int passes = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        core_req = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_core(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_wr[i] = wr;
        core_addr[i*AW +: AW] = a;
        core_wdata[i*DW +: DW] = d;
    endtask

    task automatic push(input int c, input logic [DW-1:0] d, input bit chk);
        exp_t e;
        e.core = c;
        e.data = d;
        e.chk  = chk;
        sbq.push_back(e);
    endtask

    function automatic logic [3:0] onehot(input int c);
        logic [3:0] v;
        v = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        logic ack_seen;
        rst = 1'b1;
        n_cores = 4'b0001;
        #1;
        checks++;
        if ({state, mem_en, mem_wr, mem_addr, mem_wdata, core_ack, core_rdata} !== '0)
            $display("FAIL reset_state: got state=%b en=%b wr=%b addr=%h wdata=%h ack=%b rdata=%h, required all 0",
                     state, mem_en, mem_wr, mem_addr, mem_wdata, core_ack, core_rdata);
        else passes++;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        set_core(0, 1'b1, 12'h0AB, 16'h5555);
        core_req = 4'b0001;
        tick();
        checks++;
        if (state !== S_ACC || mem_en !== 1'b1)
            $display("FAIL reset_pre_access: got state=%b en=%b, required 01/1", state, mem_en);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({state, mem_en, mem_wr, mem_addr, mem_wdata, core_ack, core_rdata} !== '0)
            $display("FAIL reset_mid_access: got state=%b en=%b wr=%b addr=%h wdata=%h ack=%b, required all 0",
                     state, mem_en, mem_wr, mem_addr, mem_wdata, core_ack);
        else passes++;
        core_req = '0;
        tick();
        tick();
        rst = 1'b0;
        ack_seen = 1'b0;
        repeat (6) begin
            tick();
            if (core_ack !== 4'b0000) ack_seen = 1'b1;
        end
        checks++;
        if (ack_seen !== 1'b0) $display("FAIL reset_no_ack: got ack after abandoned access, required none");
        else passes++;
        core_req = 4'b0001;
        repeat (3) tick();
        checks++;
        if (core_ack !== 4'b0001) $display("FAIL reset_txn_ack: got %b, required 0001", core_ack);
        else passes++;
        core_req = '0;
        tick();
        checks++;
        if (state !== S_IDLE || mem_addr !== 12'h0AB)
            $display("FAIL reset_idle_pre: got state=%b addr=%h, required 00/0ab", state, mem_addr);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({state, mem_en, mem_wr, mem_addr, mem_wdata, core_ack, core_rdata} !== '0)
            $display("FAIL reset_mid_idle: got state=%b en=%b wr=%b addr=%h wdata=%h ack=%b rdata=%h, required all 0",
                     state, mem_en, mem_wr, mem_addr, mem_wdata, core_ack, core_rdata);
        else passes++;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_rw();
        exp_t e;
        n_cores = 4'b0001;
        set_core(0, 1'b1, 12'h005, 16'h1234);
        core_req = 4'b0001;
        push(0, 16'h0000, 1'b0);
        tick();
        checks++;
        if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 12'h005 || mem_wdata !== 16'h1234)
            $display("FAIL single_wr_access: got en=%b wr=%b addr=%h wdata=%h, required 1/1/005/1234",
                     mem_en, mem_wr, mem_addr, mem_wdata);
        else passes++;
        tick();
        checks++;
        if (mem_en !== 1'b0 || state !== S_RESP)
            $display("FAIL single_wr_resp: got en=%b state=%b, required 0/10", mem_en, state);
        else passes++;
        tick();
        e = sbq.pop_front();
        checks++;
        if (core_ack !== onehot(e.core)) $display("FAIL single_wr_ack: got %b, required %b", core_ack, onehot(e.core));
        else passes++;
        core_req = '0;
        tick();
        set_core(0, 1'b0, 12'h005, 16'h0000);
        core_req = 4'b0001;
        push(0, 16'h1234, 1'b1);
        tick();
        checks++;
        if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 12'h005)
            $display("FAIL single_rd_access: got en=%b wr=%b addr=%h, required 1/0/005", mem_en, mem_wr, mem_addr);
        else passes++;
        tick();
        tick();
        e = sbq.pop_front();
        checks++;
        if (core_ack !== onehot(e.core)) $display("FAIL single_rd_ack: got %b, required %b", core_ack, onehot(e.core));
        else passes++;
        checks++;
        if (core_rdata !== e.data) $display("FAIL single_rd_data: got %h, required %h", core_rdata, e.data);
        else passes++;
        core_req = '0;
        tick();
    endtask

    task automatic test_contention();
        int last;
        last = -1;
        do_reset();
        n_cores = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            set_core(i, 1'b1, 12'(16 + i), 16'hA000 + 16'(i));
            push(i, 16'h0000, 1'b0);
        end
        core_req = 4'b1111;
        for (int n = 0; n < 40 && sbq.size() > 0; n++) begin
            tick();
            if (core_ack !== 4'b0000) begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                if (core_ack !== onehot(e.core))
                    $display("FAIL contention_order: got %b, required %b", core_ack, onehot(e.core));
                else passes++;
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 3) $display("FAIL contention_gap: got %0d cycles, required 3", cyc - last);
                    else passes++;
                end
                last = cyc;
                core_req = core_req & ~core_ack;
            end
        end
        checks++;
        if (sbq.size() != 0) $display("FAIL contention_timeout: got %0d acks pending, required 0", sbq.size());
        else passes++;
        sbq.delete();
        core_req = '0;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[16 + i] !== 16'hA000 + 16'(i))
                $display("FAIL contention_mem%0d: got %h, required %h", i, mem[16 + i], 16'hA000 + 16'(i));
            else passes++;
        end
    endtask

    task automatic test_mask();
        int  last;
        logic hi_seen;
        last = -1;
        hi_seen = 1'b0;
        do_reset();
        n_cores = 4'b0011;
        for (int i = 0; i < 4; i++) set_core(i, 1'b0, 12'(16 + i), 16'h0000);
        for (int k = 0; k < 3; k++) begin
            push(0, 16'hA000, 1'b1);
            push(1, 16'hA001, 1'b1);
        end
        core_req = 4'b1111;
        for (int n = 0; n < 60 && sbq.size() > 0; n++) begin
            tick();
            if (core_ack[3:2] !== 2'b00) hi_seen = 1'b1;
            if (core_ack !== 4'b0000) begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                if (core_ack !== onehot(e.core) || core_rdata !== e.data)
                    $display("FAIL mask_order: got ack=%b rdata=%h, required ack=%b rdata=%h",
                             core_ack, core_rdata, onehot(e.core), e.data);
                else passes++;
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 3) $display("FAIL mask_gap: got %0d cycles, required 3", cyc - last);
                    else passes++;
                end
                last = cyc;
            end
        end
        core_req = '0;
        repeat (4) begin
            tick();
            if (core_ack[3:2] !== 2'b00) hi_seen = 1'b1;
        end
        checks++;
        if (sbq.size() != 0) $display("FAIL mask_timeout: got %0d acks pending, required 0", sbq.size());
        else passes++;
        checks++;
        if (hi_seen !== 1'b0) $display("FAIL mask_high_bits: got ack on masked core, required none");
        else passes++;
        sbq.delete();
    endtask

    task automatic test_fairness();
        bit rereq;
        rereq = 1'b0;
        do_reset();
        n_cores = 4'b1111;
        set_core(0, 1'b0, 12'h010, 16'h0000);
        set_core(2, 1'b0, 12'h012, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            push(0, 16'hA000, 1'b1);
            push(2, 16'hA002, 1'b1);
        end
        core_req = 4'b0101;
        for (int n = 0; n < 60 && sbq.size() > 0; n++) begin
            tick();
            if (rereq) begin
                core_req[0] = 1'b1;
                rereq = 1'b0;
            end
            if (core_ack !== 4'b0000) begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                if (core_ack !== onehot(e.core) || core_rdata !== e.data)
                    $display("FAIL fairness_order: got ack=%b rdata=%h, required ack=%b rdata=%h",
                             core_ack, core_rdata, onehot(e.core), e.data);
                else passes++;
                if (core_ack[0]) begin
                    core_req[0] = 1'b0;
                    rereq = 1'b1;
                end
            end
        end
        checks++;
        if (sbq.size() != 0) $display("FAIL fairness_timeout: got %0d acks pending, required 0", sbq.size());
        else passes++;
        sbq.delete();
        core_req = '0;
        repeat (4) tick();
    endtask

    task automatic test_mask_change();
        do_reset();
        n_cores = 4'b1111;
        set_core(0, 1'b0, 12'h010, 16'h0000);
        set_core(3, 1'b0, 12'h013, 16'h0000);
        push(3, 16'hA003, 1'b1);
        push(0, 16'hA000, 1'b1);
        push(0, 16'hA000, 1'b1);
        core_req = 4'b1000;
        tick();
        checks++;
        if (state !== S_ACC) $display("FAIL inflight_access: got state=%b, required 01", state);
        else passes++;
        n_cores = 4'b0001;
        core_req = 4'b1001;
        for (int n = 0; n < 40 && sbq.size() > 0; n++) begin
            tick();
            if (core_ack !== 4'b0000) begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                if (core_ack !== onehot(e.core) || core_rdata !== e.data)
                    $display("FAIL inflight_order: got ack=%b rdata=%h, required ack=%b rdata=%h",
                             core_ack, core_rdata, onehot(e.core), e.data);
                else passes++;
            end
        end
        checks++;
        if (sbq.size() != 0) $display("FAIL inflight_timeout: got %0d acks pending, required 0", sbq.size());
        else passes++;
        sbq.delete();
        core_req = '0;
        repeat (4) tick();
    endtask

    task automatic test_mask_zero();
        logic bad;
        bad = 1'b0;
        do_reset();
        n_cores = 4'b0000;
        core_req = 4'b1111;
        repeat (12) begin
            tick();
            if (state !== S_IDLE || mem_en !== 1'b0 || core_ack !== 4'b0000) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) $display("FAIL mask_zero: got activity with n_cores=0000, required none");
        else passes++;
        core_req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_rw();
        test_contention();
        test_mask();
        test_fairness();
        test_mask_change();
        test_mask_zero();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d passed=%0d", checks, passes);
        $fatal(1, "watchdog expired");
    end

endmodule
